vga_text_console: RTL and testbench

Character-stream front end for the VGA text display: accepts one byte per handshake (from the CPU bus or the UART), keeps a cursor over the 100×37 character-block grid, and issues the single-cycle block writes that the VGA controller consumes. It handles newline, carriage return, backspace, line wrap and screen clear. Instead of scrolling, it wraps to the top row and clears each newly entered row. It sits between the character source and the VGA controller's `write_op`/`bus_addr`/`bus_data` write port.

---
 rtl/vga_text_console_pkg.sv | 20 ++
 rtl/console_cursor.sv | 36 +++
 rtl/vga_text_console.sv | 92 +++++++++
 tb/tb_vga_text_console.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_console_pkg.sv
// vga_text_console_pkg: shared grid geometry, ASCII codes, bus types and FSM encodings
// for the text console front end.
package vga_text_console_pkg;
  localparam int CONSOLE_COLS = 100;
  localparam int CONSOLE_ROWS = 37;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  typedef logic [31:0] Word_t;
  typedef logic Bit_t;
  typedef logic [11:0] Graphics_block_addr_t;
  typedef logic [1:0] Console_state_t;
  localparam Console_state_t IDLE = 2'd0;
  localparam Console_state_t CLEAR_LINE = 2'd1;
  localparam Console_state_t CLEAR_ALL = 2'd2;
  function automatic Bit_t is_printable(input logic [7:0] c);
    return c >= 8'h20 && c <= 8'h7E;
  endfunction
endpackage

// File: rtl/console_cursor.sv
// console_cursor: row/column cursor over the character grid with the matching
// block address and row base address.
module console_cursor
  import vga_text_console_pkg::*;
#(
  parameter int COLS = CONSOLE_COLS,
  parameter int ROWS = CONSOLE_ROWS
) (
  input  logic                 clk_25M,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 home,
  input  logic                 cr,
  input  logic                 newline,
  output logic [6:0]           col,
  output logic [5:0]           row,
  output Graphics_block_addr_t base,
  output Graphics_block_addr_t addr
);
  always_ff @(posedge clk_25M or negedge rst)
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (home) begin
      col <= '0;
      row <= '0;
    end else if (newline) begin
      col <= '0;
      row <= (row == 6'(ROWS - 1)) ? '0 : row + 6'd1;
    end else if (cr) col <= '0;
    else if (inc) col <= col + 7'd1;
    else if (dec) col <= col - 7'd1;
  assign base = Graphics_block_addr_t'(row) * Graphics_block_addr_t'(COLS);
  assign addr = base + Graphics_block_addr_t'(col);
endmodule

// File: rtl/vga_text_console.sv
// vga_text_console: turns a byte stream into VGA block writes, handling LF/CR/BS,
// line wrap with clear-on-entry of each new row, and full-screen clear.
module vga_text_console
  import vga_text_console_pkg::*;
#(
  parameter int COLS = CONSOLE_COLS,
  parameter int ROWS = CONSOLE_ROWS
) (
  input  logic        clk_25M,
  input  logic        rst,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  input  logic        clear_req,
  output logic        write_op,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data,
  output logic [6:0]  cursor_col,
  output logic [5:0]  cursor_row,
  output logic        busy
);
  localparam Graphics_block_addr_t LAST = Graphics_block_addr_t'(ROWS * COLS - 1);
  Console_state_t state;
  logic [6:0] line_k;
  Graphics_block_addr_t clr_cnt, base, addr;
  logic accept, printable, at_edge, wrap, bs_ok;
  assign char_ready = state == IDLE && !clear_req;
  assign busy = state != IDLE;
  assign accept = char_ready && char_valid;
  assign printable = is_printable(char_data);
  assign at_edge = cursor_col == 7'(COLS - 1);
  assign wrap = accept && (char_data == ASCII_LF || (printable && at_edge));
  assign bs_ok = accept && char_data == ASCII_BS && cursor_col != '0;
  console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk_25M (clk_25M),
    .rst     (rst),
    .inc     (accept && printable && !at_edge),
    .dec     (bs_ok),
    .home    (state == IDLE && clear_req),
    .cr      (accept && char_data == ASCII_CR),
    .newline (wrap),
    .col     (cursor_col),
    .row     (cursor_row),
    .base    (base),
    .addr    (addr)
  );
  // The final clear write and the return to IDLE share one edge.
  always_ff @(posedge clk_25M or negedge rst)
    if (!rst) begin
      state <= CLEAR_ALL;
      line_k <= '0;
      clr_cnt <= '0;
      write_op <= 1'b0;
      bus_addr <= '0;
      bus_data <= '0;
    end else begin
      write_op <= 1'b0;
      bus_addr <= '0;
      bus_data <= '0;
      case (state)
        IDLE:
          if (clear_req) begin
            state <= CLEAR_ALL;
            clr_cnt <= '0;
          end else if (accept) begin
            if (printable || bs_ok) begin
              write_op <= 1'b1;
              bus_addr <= 32'(printable ? addr : addr - 12'd1);
              bus_data <= {24'b0, printable ? char_data : ASCII_SPACE};
            end
            if (wrap) begin
              state <= CLEAR_LINE;
              line_k <= '0;
            end
          end
        CLEAR_LINE: begin
          write_op <= 1'b1;
          bus_addr <= 32'(base + Graphics_block_addr_t'(line_k));
          bus_data <= 32'(ASCII_SPACE);
          line_k <= line_k + 7'd1;
          if (line_k == 7'(COLS - 1)) state <= IDLE;
        end
        default: begin
          write_op <= 1'b1;
          bus_addr <= 32'(clr_cnt);
          bus_data <= 32'(ASCII_SPACE);
          clr_cnt <= clr_cnt + 12'd1;
          if (clr_cnt == LAST) state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_vga_text_console.sv
// tb_vga_text_console: directed scenarios plus a random byte stream, checked against
// a screen-level model of cursor movement and the block writes each byte implies.
module tb_vga_text_console;
  localparam int COLS = 100;
  localparam int ROWS = 37;
  logic clk_25M = 0, rst = 0, char_valid = 0, clear_req = 0;
  logic [7:0] char_data = 0;
  logic char_ready, write_op, busy;
  logic [31:0] bus_addr, bus_data;
  logic [6:0] cursor_col;
  logic [5:0] cursor_row;
  vga_text_console dut (
    .clk_25M(clk_25M), .rst(rst), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .clear_req(clear_req), .write_op(write_op),
    .bus_addr(bus_addr), .bus_data(bus_data), .cursor_col(cursor_col),
    .cursor_row(cursor_row), .busy(busy)
  );
  always #20 clk_25M = ~clk_25M;
  typedef struct {int cyc; int addr; int data;} wr_t;
  wr_t got[$];
  wr_t exp_q[$];
  int cyc = 0, tests = 0, fails = 0, mrow = 0, mcol = 0, low_cnt = 0, rise_cyc = -1;
  bit rdy_q = 0;
  always @(posedge clk_25M) cyc++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
    end
  endtask
  always @(negedge clk_25M) begin
    if (write_op) got.push_back('{cyc, int'(bus_addr), int'(bus_data)});
    else if (rst) chk("idle_bus_zero", bus_addr | bus_data, 0);
    if (!char_ready) low_cnt++;
    if (char_ready && !rdy_q) rise_cyc = cyc;
    rdy_q = char_ready;
  end
  function automatic int gw(input int i, input int f);
    if (i < 0 || i >= got.size()) return -1000;
    return f == 0 ? got[i].cyc : f == 1 ? got[i].addr : got[i].data;
  endfunction
  task automatic tick;
    @(posedge clk_25M);
    #1;
  endtask
  task automatic push(input int a, input int d);
    exp_q.push_back('{0, a, d});
  endtask
  task automatic newrow;
    mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
    for (int k = 0; k < COLS; k++) push(mrow * COLS + k, 32);
  endtask
  task automatic model_clear_all;
    mrow = 0;
    mcol = 0;
    for (int i = 0; i < ROWS * COLS; i++) push(i, 32);
  endtask
  task automatic model(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      push(mrow * COLS + mcol, int'(c));
      if (mcol < COLS - 1) mcol++;
      else begin
        mcol = 0;
        newrow();
      end
    end else if (c == 8'h0A) begin
      mcol = 0;
      newrow();
    end else if (c == 8'h0D) mcol = 0;
    else if (c == 8'h08 && mcol > 0) begin
      mcol--;
      push(mrow * COLS + mcol, 32);
    end
  endtask
  task automatic send(input logic [7:0] c, output int acc);
    char_valid = 1;
    char_data = c;
    for (int i = 0; i < 5000 && !char_ready; i++) tick();
    chk("send_ready", char_ready, 1);
    acc = cyc;
    tick();
    char_valid = 0;
    model(c);
  endtask
  task automatic drain;
    for (int n = 0; n < 6000 && (busy || !char_ready); n++) tick();
    chk("drain_idle", busy, 0);
    tick();
  endtask
  task automatic check_writes(input string tag, input bit prefix);
    int bad = -1;
    if (prefix) chk({tag, "_count"}, got.size() > 0 && got.size() <= exp_q.size(), 1);
    else chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (bad < 0 && (got[i].addr != exp_q[i].addr || got[i].data != exp_q[i].data)) bad = i;
    chk({tag, "_first_bad_index"}, bad, -1);
    chk({tag, "_col"}, cursor_col, mcol);
    chk({tag, "_row"}, cursor_row, mrow);
    got.delete();
    exp_q.delete();
  endtask
  function automatic logic [7:0] rp();
    return 8'($urandom_range(32, 126));
  endfunction
  initial begin
    int acc, a0, r0, n;
    logic [7:0] c;
    repeat (3) tick();
    chk("rst_write_op", write_op, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_data", bus_data, 0);
    chk("rst_ready", char_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_cursor", {cursor_row, cursor_col}, 0);
    model_clear_all();
    rst = 1;
    r0 = cyc;
    drain();
    chk("boot_first_cycle", gw(0, 0) - r0, 1);
    chk("boot_span", gw(got.size() - 1, 0) - gw(0, 0), ROWS * COLS - 1);
    chk("boot_ready_rise", rise_cyc == gw(got.size() - 1, 0) || rise_cyc == gw(got.size() - 1, 0) + 1, 1);
    check_writes("boot", 0);
    send(8'h0A, acc);
    repeat (3) send(rp(), acc);
    send(8'h08, acc);
    drain();
    chk("bs_addr", gw(got.size() - 1, 1), 102);
    chk("bs_data", gw(got.size() - 1, 2), 32);
    chk("bs_cursor", {cursor_row, cursor_col}, {6'd1, 7'd2});
    check_writes("bs", 0);
    send(8'h0A, acc);
    repeat (5) send(rp(), acc);
    drain();
    chk("ab_start", {cursor_row, cursor_col}, {6'd2, 7'd5});
    check_writes("pre_ab", 0);
    char_valid = 1;
    char_data = 8'h41;
    chk("ab_ready_a", char_ready, 1);
    a0 = cyc;
    tick();
    chk("ab_ready_b", char_ready, 1);
    char_data = 8'h42;
    tick();
    char_valid = 0;
    model(8'h41);
    model(8'h42);
    drain();
    chk("ab_a_cycle", gw(0, 0) - a0, 1);
    chk("ab_b_cycle", gw(1, 0) - a0, 2);
    chk("ab_a_addr", gw(0, 1), 205);
    chk("ab_b_addr", gw(1, 1), 206);
    chk("ab_cursor", {cursor_row, cursor_col}, {6'd2, 7'd7});
    check_writes("ab", 0);
    send(8'h0A, acc);
    repeat (10) send(rp(), acc);
    drain();
    chk("ctl_start", {cursor_row, cursor_col}, {6'd3, 7'd10});
    check_writes("pre_ctl", 0);
    send(8'h0D, acc);
    repeat (3) tick();
    chk("cr_no_write", got.size(), 0);
    chk("cr_col", cursor_col, 0);
    send(8'h08, acc);
    repeat (3) tick();
    chk("bs0_no_write", got.size(), 0);
    chk("bs0_col", cursor_col, 0);
    send(8'h0A, acc);
    drain();
    chk("lf_first_cycle", gw(0, 0) - acc, 2);
    chk("lf_last_cycle", gw(got.size() - 1, 0) - acc, COLS + 1);
    chk("lf_first_addr", gw(0, 1), 400);
    chk("lf_last_addr", gw(got.size() - 1, 1), 499);
    chk("lf_cursor", {cursor_row, cursor_col}, {6'd4, 7'd0});
    check_writes("lf", 0);
    repeat (32) send(8'h0A, acc);
    repeat (99) send(rp(), acc);
    drain();
    chk("wrap_start", {cursor_row, cursor_col}, {6'd36, 7'd99});
    check_writes("to_bottom", 0);
    low_cnt = 0;
    send(8'h5A, acc);
    drain();
    chk("wrap_low_cycles", low_cnt, COLS);
    chk("wrap_char_cycle", gw(0, 0) - acc, 1);
    chk("wrap_char_addr", gw(0, 1), 3699);
    chk("wrap_char_data", gw(0, 2), 32'h5A);
    chk("wrap_clear_last", gw(COLS, 1), COLS - 1);
    chk("wrap_cursor", {cursor_row, cursor_col}, 0);
    check_writes("wrap", 0);
    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(0, 9);
      c = n < 6 ? rp() : n == 6 ? 8'h0A : n == 7 ? 8'h0D : n == 8 ? 8'h08 :
          ($urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(127, 255)));
      send(c, acc);
      repeat ($urandom_range(0, 2)) tick();
      if (i % 50 == 49) begin
        drain();
        check_writes("random", 0);
      end
    end
    clear_req = 1;
    char_valid = 1;
    char_data = 8'h41;
    #1;
    chk("prio_ready_low", char_ready, 0);
    a0 = cyc;
    tick();
    clear_req = 0;
    char_valid = 0;
    model_clear_all();
    repeat (600) tick();
    chk("clr_first_cycle", gw(0, 0) - a0, 2);
    chk("clr_busy", busy, 1);
    check_writes("clr_prefix", 1);
    rst = 0;
    #1;
    chk("abort_write_op", write_op, 0);
    chk("abort_addr", bus_addr, 0);
    chk("abort_data", bus_data, 0);
    chk("abort_ready", char_ready, 0);
    chk("abort_busy", busy, 1);
    chk("abort_cursor", {cursor_row, cursor_col}, 0);
    tick();
    tick();
    got.delete();
    exp_q.delete();
    model_clear_all();
    rst = 1;
    r0 = cyc;
    drain();
    chk("reboot_first_cycle", gw(0, 0) - r0, 1);
    chk("reboot_first_addr", gw(0, 1), 0);
    check_writes("reboot", 0);
    repeat (20) send(rp(), acc);
    drain();
    check_writes("final", 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
